// File: rtl/assembler_constants.sv
// Shared constants and state encodings for the assembler front end.
package assembler_constants;

    // ASCII codes the feeder treats specially
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_TAB   = 8'h09;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_HASH  = 8'h23;
    localparam logic [7:0] ASCII_SEMI  = 8'h3B;
    localparam logic [7:0] ASCII_NUL   = 8'h00;

    // Feeder control states
    typedef enum logic [2:0] {
        IDLE,
        LINE,
        COMMENT,
        WAIT_INST,
        ERROR,
        DONE
    } feeder_state_t;

    // Byte classes produced by char_classifier
    typedef enum logic [2:0] {
        CLS_CONTENT,
        CLS_SPACE,
        CLS_LF,
        CLS_CR,
        CLS_COMMENT,
        CLS_EOS
    } char_class_t;

    // What ended the current line, i.e. where to go once the parser is done
    typedef enum logic [1:0] {
        EOL_LF,
        EOL_COMMENT,
        EOL_EOS
    } eol_kind_t;

endpackage

// File: rtl/source_line_feeder_char_classifier.sv
// Combinational byte classifier: class code plus lowercase-folded byte.
module char_classifier
    import assembler_constants::*;
(
    input  logic [7:0]  char_in,
    output char_class_t char_class,
    output logic [7:0]  char_lower
);

    // Decode the byte class and fold 'A'-'Z' to lowercase
    always_comb begin
        char_class = CLS_CONTENT;
        char_lower = char_in;
        if (char_in >= 8'h41 && char_in <= 8'h5A) begin
            char_lower = char_in + 8'h20;
        end
        case (char_in)
            ASCII_CR:                char_class = CLS_CR;
            ASCII_TAB, ASCII_SPACE:  char_class = CLS_SPACE;
            ASCII_LF:                char_class = CLS_LF;
            ASCII_HASH, ASCII_SEMI:  char_class = CLS_COMMENT;
            ASCII_NUL:               char_class = CLS_EOS;
            default:                 char_class = CLS_CONTENT;
        endcase
    end

endmodule

// File: rtl/source_line_feeder.sv
// Source line feeder: normalises the raw source byte stream and presents
// each non-blank line to the instruction parser one character at a time.
//
// Handshake: a source byte transfers on a rising clk_in edge where
// char_valid_in && char_ready_out; char_ready_out is registered and only
// high in IDLE/LINE/COMMENT with the one-byte hold register empty.
module source_line_feeder
    import assembler_constants::*;
#(
    parameter int CHAR_PER_LINE = 64,
    parameter int LINE_W        = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              char_valid_in,
    input  logic [7:0]        char_in,
    output logic              char_ready_out,
    input  logic              inst_ready_in,
    input  logic              inst_error_in,
    output logic              new_line,
    output logic              new_character,
    output logic [7:0]        incoming_character,
    output logic [LINE_W-1:0] line_number,
    output logic              overflow_error,
    output logic              parse_error,
    output logic              done,
    output feeder_state_t     state_dbg
);

    localparam int CNT_W = $clog2(CHAR_PER_LINE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAR_PER_LINE);

    feeder_state_t     state_q, state_d;
    eol_kind_t         eol_q, eol_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              space_pending_q, space_pending_d;
    logic              hold_valid_q, hold_valid_d;
    logic [7:0]        hold_char_q, hold_char_d;
    logic              ready_q, ready_d;
    logic              new_line_q, new_line_d;
    logic              new_char_q, new_char_d;
    logic [7:0]        incoming_q, incoming_d;
    logic              overflow_q, overflow_d;
    logic              parse_err_q, parse_err_d;
    logic              done_q, done_d;

    char_class_t       cls;
    logic [7:0]        lower;
    logic              accept;
    logic              emit_req;
    logic [7:0]        emit_char;

    char_classifier u_classifier (
        .char_in    (char_in),
        .char_class (cls),
        .char_lower (lower)
    );

    assign accept = char_valid_in && ready_q;

    // Next-state and next-output decode
    always_comb begin
        state_d         = state_q;
        eol_d           = eol_q;
        count_d         = count_q;
        line_d          = line_q;
        space_pending_d = space_pending_q;
        hold_valid_d    = hold_valid_q;
        hold_char_d     = hold_char_q;
        new_line_d      = 1'b0;
        new_char_d      = 1'b0;
        incoming_d      = incoming_q;
        overflow_d      = overflow_q;
        parse_err_d     = parse_err_q;
        done_d          = done_q;
        emit_req        = 1'b0;
        emit_char       = 8'h00;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (cls)
                        CLS_LF:      line_d = line_q + LINE_W'(1);
                        CLS_COMMENT: state_d = COMMENT;
                        CLS_EOS: begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                        CLS_CONTENT: begin
                            // First char is parked so new_line leads it by a cycle
                            new_line_d   = 1'b1;
                            hold_valid_d = 1'b1;
                            hold_char_d  = lower;
                            state_d      = LINE;
                        end
                        default: ;
                    endcase
                end
            end

            LINE: begin
                if (hold_valid_q) begin
                    emit_req     = 1'b1;
                    emit_char    = hold_char_q;
                    hold_valid_d = 1'b0;
                end else if (accept) begin
                    case (cls)
                        CLS_SPACE: space_pending_d = 1'b1;
                        CLS_CONTENT: begin
                            if (space_pending_q) begin
                                // Collapsed space goes out first, the char follows
                                emit_req        = 1'b1;
                                emit_char       = ASCII_SPACE;
                                hold_valid_d    = 1'b1;
                                hold_char_d     = lower;
                                space_pending_d = 1'b0;
                            end else begin
                                emit_req  = 1'b1;
                                emit_char = lower;
                            end
                        end
                        CLS_LF, CLS_COMMENT, CLS_EOS: begin
                            // Trailing whitespace is dropped with the pending flag
                            space_pending_d = 1'b0;
                            state_d         = WAIT_INST;
                            if (cls == CLS_LF) begin
                                eol_d = EOL_LF;
                            end else if (cls == CLS_COMMENT) begin
                                eol_d = EOL_COMMENT;
                            end else begin
                                eol_d = EOL_EOS;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            COMMENT: begin
                if (accept) begin
                    if (cls == CLS_LF) begin
                        line_d  = line_q + LINE_W'(1);
                        state_d = IDLE;
                    end else if (cls == CLS_EOS) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            WAIT_INST: begin
                if (inst_error_in) begin
                    parse_err_d = 1'b1;
                    state_d     = ERROR;
                end else if (inst_ready_in) begin
                    count_d = '0;
                    case (eol_q)
                        EOL_COMMENT: state_d = COMMENT;
                        EOL_EOS: begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                        default: begin
                            state_d = IDLE;
                            line_d  = line_q + LINE_W'(1);
                        end
                    endcase
                end
            end

            default: ;
        endcase

        // Every emitted char counts against the line limit
        if (emit_req) begin
            if (count_q == CNT_MAX) begin
                overflow_d   = 1'b1;
                state_d      = ERROR;
                hold_valid_d = 1'b0;
            end else begin
                new_char_d = 1'b1;
                incoming_d = emit_char;
                count_d    = count_q + CNT_W'(1);
            end
        end

        ready_d = ((state_d == IDLE) || (state_d == LINE) || (state_d == COMMENT))
                  && !hold_valid_d;
    end

    // State and output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= IDLE;
            eol_q           <= EOL_LF;
            count_q         <= '0;
            line_q          <= LINE_W'(1);
            space_pending_q <= 1'b0;
            hold_valid_q    <= 1'b0;
            hold_char_q     <= 8'h00;
            ready_q         <= 1'b1;
            new_line_q      <= 1'b0;
            new_char_q      <= 1'b0;
            incoming_q      <= 8'h00;
            overflow_q      <= 1'b0;
            parse_err_q     <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            eol_q           <= eol_d;
            count_q         <= count_d;
            line_q          <= line_d;
            space_pending_q <= space_pending_d;
            hold_valid_q    <= hold_valid_d;
            hold_char_q     <= hold_char_d;
            ready_q         <= ready_d;
            new_line_q      <= new_line_d;
            new_char_q      <= new_char_d;
            incoming_q      <= incoming_d;
            overflow_q      <= overflow_d;
            parse_err_q     <= parse_err_d;
            done_q          <= done_d;
        end
    end

    assign char_ready_out     = ready_q;
    assign new_line           = new_line_q;
    assign new_character      = new_char_q;
    assign incoming_character = incoming_q;
    assign line_number        = line_q;
    assign overflow_error     = overflow_q;
    assign parse_error        = parse_err_q;
    assign done               = done_q;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_source_line_feeder.sv
// Bench for source_line_feeder: directed source text, expected pulse
// stream queued up front and checked by an independent monitor.
module tb_source_line_feeder;
    import assembler_constants::*;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          char_valid_in;
    logic [7:0]    char_in;
    logic          char_ready_out;
    logic          inst_ready_in;
    logic          inst_error_in;
    logic          new_line;
    logic          new_character;
    logic [7:0]    incoming_character;
    logic [15:0]   line_number;
    logic          overflow_error;
    logic          parse_error;
    logic          done;
    feeder_state_t state_dbg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nl_cyc = 0;
    bit first_pending = 0;

    // Entry: {is_new_line, line_number (new_line only), char (char only)}
    logic [24:0] exp_q[$];

    source_line_feeder #(.CHAR_PER_LINE(64), .LINE_W(16)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .char_valid_in      (char_valid_in),
        .char_in            (char_in),
        .char_ready_out     (char_ready_out),
        .inst_ready_in      (inst_ready_in),
        .inst_error_in      (inst_error_in),
        .new_line           (new_line),
        .new_character      (new_character),
        .incoming_character (incoming_character),
        .line_number        (line_number),
        .overflow_error     (overflow_error),
        .parse_error        (parse_error),
        .done               (done),
        .state_dbg          (state_dbg)
    );

    // Clock
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output pulse
    always @(negedge clk_in) begin
        logic [24:0] act;
        logic [24:0] exp;
        cyc++;
        if (!rst_in) begin
            if (new_line) begin
                act = {1'b1, line_number, 8'h00};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_new_line: got %0h expected none", act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        bad++;
                        $display("FAIL new_line_event: got %0h expected %0h", act, exp);
                    end
                end
                nl_cyc = cyc;
                first_pending = 1;
            end
            if (new_character) begin
                act = {1'b0, 16'h0000, incoming_character};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_char: got %0h expected none", act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        bad++;
                        $display("FAIL char_event: got %0h expected %0h", act, exp);
                    end
                end
                if (first_pending) begin
                    check("first_char_latency", cyc - nl_cyc, 1);
                    first_pending = 0;
                end
            end
        end
    end

    // Driver tasks
    task automatic expect_line(input int ln, input string s);
        exp_q.push_back({1'b1, 16'(ln), 8'h00});
        for (int i = 0; i < s.len(); i++) begin
            exp_q.push_back({1'b0, 16'h0000, 8'(s[i])});
        end
    endtask

    task automatic do_reset();
        rst_in        = 1'b1;
        char_valid_in = 1'b0;
        char_in       = 8'h00;
        inst_ready_in = 1'b0;
        inst_error_in = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        first_pending = 0;
    endtask

    task automatic send_byte(input logic [7:0] c);
        int waited;
        waited = 0;
        char_valid_in = 1'b1;
        char_in       = c;
        while (!char_ready_out && waited < 200) begin
            @(posedge clk_in);
            @(negedge clk_in);
            waited++;
        end
        if (waited >= 200) begin
            check("send_timeout", 32'(c), 32'hFFFF);
        end else begin
            @(posedge clk_in);
            @(negedge clk_in);
        end
        char_valid_in = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(8'(s[i]));
        end
    endtask

    task automatic ack_line(input bit with_error);
        int waited;
        waited = 0;
        while (state_dbg != WAIT_INST && waited < 50) begin
            @(posedge clk_in);
            @(negedge clk_in);
            waited++;
        end
        if (waited >= 50) begin
            check("wait_inst_timeout", 32'(state_dbg), 32'(WAIT_INST));
        end
        inst_ready_in = 1'b1;
        inst_error_in = with_error;
        @(posedge clk_in);
        @(negedge clk_in);
        inst_ready_in = 1'b0;
        inst_error_in = 1'b0;
    endtask

    task automatic drain_check(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk_in);
        end
        check(name, exp_q.size(), 0);
    endtask

    // Stimulus
    initial begin
        do_reset();
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_line", line_number, 1);
        check("rst_pulses", {new_line, new_character}, 0);
        check("rst_incoming", incoming_character, 0);
        check("rst_flags", {overflow_error, parse_error, done}, 0);
        check("rst_ready", char_ready_out, 1);

        // Uppercase folding and space collapse
        expect_line(1, "add x1, x2,x3");
        send_str("ADD x1, x2,x3\n");
        check("t1_wait_ready", char_ready_out, 0);
        ack_line(0);
        check("t1_line", line_number, 2);
        check("t1_state", 32'(state_dbg), 32'(IDLE));
        drain_check("t1_drain");

        // Leading/trailing whitespace and trailing comment
        expect_line(2, "addi x5 ,x0, 7");
        send_str("  \t addi   x5 ,x0, 7  #");
        ack_line(0);
        check("t2_in_comment", 32'(state_dbg), 32'(COMMENT));
        send_str(" c\n");
        check("t2_line", line_number, 3);
        check("t2_state", 32'(state_dbg), 32'(IDLE));
        drain_check("t2_drain");

        // Blank, comment-only and CR-only lines produce no pulses
        do_reset();
        send_str("\n# only comment\n");
        send_byte(8'h0D);
        send_str("\n");
        check("t3_line_before_nop", line_number, 4);
        check("t3_no_pulses_yet", exp_q.size(), 0);
        expect_line(4, "nop");
        send_str("nop\n");

        // Source held valid while the parser is busy
        char_valid_in = 1'b1;
        char_in       = 8'h78;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            check("t4_stall_ready", char_ready_out, 0);
        end
        check("t4_stall_state", 32'(state_dbg), 32'(WAIT_INST));
        expect_line(5, "x");
        ack_line(0);
        send_byte(8'h78);
        send_str("\n");
        ack_line(0);
        check("t4_line", line_number, 6);
        drain_check("t4_drain");

        // Line overflow: 65 chars with a 64-char limit
        do_reset();
        exp_q.push_back({1'b1, 16'd1, 8'h00});
        for (int i = 0; i < 64; i++) exp_q.push_back({1'b0, 16'h0000, 8'h61});
        for (int i = 0; i < 65; i++) send_byte(8'h61);
        repeat (3) @(negedge clk_in);
        check("t5_overflow", overflow_error, 1);
        check("t5_ready", char_ready_out, 0);
        check("t5_state", 32'(state_dbg), 32'(ERROR));
        check("t5_parse_err", parse_error, 0);
        drain_check("t5_drain");

        // Parser error on line 3 (error wins over ready)
        do_reset();
        expect_line(1, "nop");
        send_str("nop\n");
        ack_line(0);
        send_str("\n");
        expect_line(3, "bad");
        send_str("bad\n");
        ack_line(1);
        repeat (2) @(negedge clk_in);
        check("t6_parse_err", parse_error, 1);
        check("t6_line", line_number, 3);
        check("t6_state", 32'(state_dbg), 32'(ERROR));
        check("t6_ready", char_ready_out, 0);
        check("t6_done", done, 0);
        drain_check("t6_drain");

        // End of source without a final LF
        do_reset();
        expect_line(1, "nop");
        send_str("nop");
        send_byte(8'h00);
        check("t7_wait_state", 32'(state_dbg), 32'(WAIT_INST));
        check("t7_not_done", done, 0);
        ack_line(0);
        check("t7_done", done, 1);
        check("t7_line", line_number, 1);
        check("t7_ready", char_ready_out, 0);
        drain_check("t7_drain");

        // Reset in the middle of a line
        do_reset();
        expect_line(1, "ab");
        send_str("ab");
        drain_check("t8_drain");
        check("t8_mid_state", 32'(state_dbg), 32'(LINE));
        rst_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        check("t8_rst_state", 32'(state_dbg), 32'(IDLE));
        check("t8_rst_pulses", {new_line, new_character}, 0);
        check("t8_rst_incoming", incoming_character, 0);
        check("t8_rst_line", line_number, 1);
        check("t8_rst_ready", char_ready_out, 1);
        rst_in = 1'b0;
        repeat (5) @(negedge clk_in);
        check("t8_quiet", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
